// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit radix-2 divider for DIV/DIVU
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst           in   1  asynchronous reset, active-high
//   signed_div_i  in   1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
//   opdata1_i     in  32  dividend; sampled with start_i
//   opdata2_i     in  32  divisor; sampled with start_i
//   start_i       in   1  request, held high until ready_o has been consumed
//   annul_i       in   1  pipeline flush, aborts an operation in progress
//   result_o      out 64  {remainder, quotient}, zero unless ready_o is high
//   ready_o       out  1  result valid (registered)

module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_BY_ZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t      r_state,   w_state_nxt;
    logic [5:0]  r_cnt,     w_cnt_nxt;
    logic [64:0] r_work,    w_work_nxt;
    logic [31:0] r_divisor, w_divisor_nxt;
    logic        r_signed,  w_signed_nxt;
    logic        r_neg_q,   w_neg_q_nxt;
    logic        r_neg_r,   w_neg_r_nxt;
    logic        r_ready,   w_ready_nxt;
    logic [63:0] r_result,  w_result_nxt;

    logic [31:0] w_op1_abs;
    logic [31:0] w_op2_abs;
    logic [32:0] w_diff;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    // Magnitudes are only taken in signed mode; 0x80000000 maps onto itself,
    // which is the correct unsigned magnitude 2^31.
    assign w_op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Partial remainder sits in work[64:33]; work[32] is the next dividend bit
    // being brought down. A set bit 32 of the difference means "does not fit".
    assign w_diff = r_work[64:32] - {1'b0, r_divisor};

    assign w_q     = r_work[31:0];
    assign w_r     = r_work[64:33];
    assign w_q_fix = (r_signed && r_neg_q) ? (~w_q + 32'd1) : w_q;
    assign w_r_fix = (r_signed && r_neg_r) ? (~w_r + 32'd1) : w_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_ready   <= 1'b0;
            r_result  <= 64'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_signed  <= w_signed_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_ready   <= w_ready_nxt;
            r_result  <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_signed_nxt  = r_signed;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_ready_nxt   = r_ready;
        w_result_nxt  = r_result;

        case (r_state)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        w_state_nxt = S_BY_ZERO;
                    end else begin
                        w_state_nxt   = S_ON;
                        w_cnt_nxt     = 6'd0;
                        w_work_nxt    = {32'd0, w_op1_abs, 1'b0};
                        w_divisor_nxt = w_op2_abs;
                        w_signed_nxt  = signed_div_i;
                        w_neg_q_nxt   = opdata1_i[31] ^ opdata2_i[31];
                        w_neg_r_nxt   = opdata1_i[31];
                    end
                end
            end

            S_BY_ZERO: begin
                // No trap is raised; zero is the defined result.
                w_state_nxt  = S_END;
                w_result_nxt = 64'd0;
                w_ready_nxt  = 1'b1;
            end

            S_ON: begin
                if (annul_i) begin
                    w_state_nxt = S_FREE;
                    w_cnt_nxt   = 6'd0;
                end else if (r_cnt != 6'd32) begin
                    if (w_diff[32]) begin
                        w_work_nxt = {r_work[63:0], 1'b0};
                    end else begin
                        w_work_nxt = {w_diff[31:0], r_work[31:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    w_state_nxt  = S_END;
                    w_result_nxt = {w_r_fix, w_q_fix};
                    w_ready_nxt  = 1'b1;
                end
            end

            S_END: begin
                // Flush is deliberately ignored here: the result is already final.
                if (!start_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = 64'd0;
                end
            end

            default: begin
                w_state_nxt  = S_FREE;
                w_ready_nxt  = 1'b0;
                w_result_nxt = 64'd0;
            end
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed-vector self-checking bench for div_unit

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks;
    int n_errors;

    div_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, measure edges from the start sample to ready_o,
    // hold start for hold_n further edges, then release and check the clear.
    task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input int hold_n, input bit wiggle);
        int lat;
        bit dirty;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        lat   = 0;
        dirty = 1'b0;
        while (!ready_o && lat < 100) begin
            if (result_o != 64'd0) dirty = 1'b1;
            if (wiggle) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        check({tag, "_lat"},   64'(lat),   64'(exp_lat));
        check({tag, "_busy0"}, 64'(dirty), 64'd0);
        check({tag, "_res"},   result_o,   exp_res);
        for (int i = 0; i < hold_n; i++) begin
            tick();
            check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
            check({tag, "_hold_res"}, result_o,     exp_res);
        end
        start_i = 1'b0;
        tick();
        check({tag, "_clr_rdy"}, 64'(ready_o), 64'd0);
        check({tag, "_clr_res"}, result_o,     64'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) tick();
        check("reset_rdy", 64'(ready_o), 64'd0);
        check("reset_res", result_o,     64'd0);
        rst = 1'b0;
        tick();

        do_op("divu_ffff_16",  1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}, 33, 1, 1'b0);
        do_op("div_m7_2",      1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1, 1'b0);
        do_op("div_7_m2",      1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 1, 1'b0);
        do_op("divu_m7_2",     1'b0, 32'hFFFF_FFF9, 32'h0000_0002, {32'h0000_0001, 32'h7FFF_FFFC}, 33, 1, 1'b0);
        do_op("div_m8_m3",     1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h0000_0002}, 33, 1, 1'b0);
        do_op("divu_5_9",      1'b0, 32'h0000_0005, 32'h0000_0009, {32'h0000_0005, 32'h0000_0000}, 33, 1, 1'b0);
        do_op("div_ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, 1, 1'b0);
        do_op("div_by_zero",   1'b1, 32'h0000_1234, 32'h0000_0000, 64'd0, 1, 5, 1'b0);
        do_op("div_wiggle",    1'b1, 32'hFFFF_FF9C, 32'h0000_0007, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 1, 1'b1);

        // Annul at iteration 10, then restart on the very next edge.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (ready_o) seen = 1'b1;
            tick();
        end
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        if (ready_o) seen = 1'b1;
        check("annul_no_rdy", 64'(seen), 64'd0);
        do_op("annul_restart", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1, 1'b0);

        // Asynchronous reset in the middle of iterating.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        repeat (19) tick();
        #3;
        rst = 1'b1;
        #1;
        check("rst_on_rdy", 64'(ready_o), 64'd0);
        check("rst_on_res", result_o,     64'd0);
        start_i = 1'b0;
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen = 1'b1;
            tick();
        end
        check("rst_on_aborted", 64'(seen), 64'd0);

        // Asynchronous reset while a result is being held.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        tick();
        lat = 0;
        while (!ready_o && lat < 100) begin
            tick();
            lat++;
        end
        check("rst_end_res", result_o, {32'd0, 32'd10});
        #3;
        rst = 1'b1;
        #1;
        check("rst_end_rdy",   64'(ready_o), 64'd0);
        check("rst_end_clr",   result_o,     64'd0);
        start_i = 1'b0;
        tick();
        rst = 1'b0;

        do_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
